// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Frame layout: sync byte, 16-bit little-endian word count, then packed data bytes.
package imem_loader_pkg;

   localparam int BYTE_W         = 8;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
   localparam int LEN_W          = 16;

   localparam logic [BYTE_W-1:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_CSUM   = 3'd5,
      S_DONE   = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   // States in which the loader is willing to take a byte from the source.
   function automatic logic accepts_bytes(input state_t s);
      return (s == S_IDLE) || (s == S_LEN_LO) || (s == S_LEN_HI) ||
             (s == S_DATA) || (s == S_CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four bytes into a little-endian 32-bit word; byte k lands in bits [8k+7:8k].
// word_rdy flags the cycle the fourth byte is taken; the full word is visible one cycle later.
module word_assembler
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [WORD_W-1:0] word,
   output logic              word_rdy
);

   logic [1:0]        cnt_reg;
   logic [1:0]        cnt_next;
   logic [WORD_W-1:0] word_reg;
   logic [WORD_W-1:0] word_next;

   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         assign word_next[gi*BYTE_W +: BYTE_W] =
            (byte_valid && (cnt_reg == 2'(gi))) ? byte_data : word_reg[gi*BYTE_W +: BYTE_W];
      end
   endgenerate

   assign cnt_next = byte_valid ? cnt_reg + 2'd1 : cnt_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg  <= '0;
         word_reg <= '0;
      end else begin
         cnt_reg  <= cnt_next;
         word_reg <= word_next;
      end
   end

   assign word     = word_reg;
   assign word_rdy = byte_valid && (cnt_reg == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for the riscv instruction memory; holds the core in reset
// until the image is written. Optional trailing XOR checksum: define IMEM_LOADER_CSUM_EN.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                ADDR_W    = 8,
   parameter int                BASE_ADDR = 0,
   parameter logic [BYTE_W-1:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [WORD_W-1:0] imem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   // Largest word count that still fits between BASE_ADDR and the top of memory.
   localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'((2**ADDR_W) - BASE_ADDR);

   state_t            state_reg;
   state_t            state_next;
   logic [BYTE_W-1:0] len_lo_reg;
   logic [BYTE_W-1:0] len_lo_next;
   logic [LEN_W-1:0]  len_reg;
   logic [LEN_W-1:0]  len_next;
   logic [LEN_W:0]    idx_reg;
   logic [LEN_W:0]    idx_next;
   logic [BYTE_W-1:0] csum_reg;
   logic [BYTE_W-1:0] csum_next;

   logic              xfer;
   logic              asm_valid;
   logic              asm_word_rdy;
   logic [WORD_W-1:0] asm_word;
   logic [LEN_W-1:0]  len_cand;
   logic [LEN_W:0]    idx_inc;

   assign in_ready  = accepts_bytes(state_reg);
   assign xfer      = in_valid && in_ready;
   assign asm_valid = xfer && (state_reg == S_DATA);
   assign len_cand  = {in_data, len_lo_reg};
   assign idx_inc   = idx_reg + 1'b1;

   word_assembler u_word_assembler (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (asm_valid),
      .byte_data  (in_data),
      .word       (asm_word),
      .word_rdy   (asm_word_rdy)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         len_lo_reg <= '0;
         len_reg    <= '0;
         idx_reg    <= '0;
         csum_reg   <= '0;
      end else begin
         state_reg  <= state_next;
         len_lo_reg <= len_lo_next;
         len_reg    <= len_next;
         idx_reg    <= idx_next;
         csum_reg   <= csum_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      len_lo_next = len_lo_reg;
      len_next    = len_reg;
      idx_next    = idx_reg;
      csum_next   = csum_reg;

      case (state_reg)
         S_IDLE: begin
            if (xfer && (in_data == SYNC_BYTE)) state_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (xfer) begin
               len_lo_next = in_data;
               state_next  = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (xfer) begin
               len_next = len_cand;
               if (len_cand == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
                  state_next = S_CSUM;
`else
                  state_next = S_DONE;
`endif
               end else if ({1'b0, len_cand} > MAX_WORDS) begin
                  state_next = S_ERR;
               end else begin
                  state_next = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (xfer) csum_next = csum_reg ^ in_data;
            if (asm_word_rdy) state_next = S_WRITE;
         end
         S_WRITE: begin
            idx_next = idx_inc;
            if (idx_inc == {1'b0, len_reg}) begin
`ifdef IMEM_LOADER_CSUM_EN
               state_next = S_CSUM;
`else
               state_next = S_DONE;
`endif
            end else begin
               state_next = S_DATA;
            end
         end
         S_CSUM: begin
            if (xfer) state_next = (in_data == csum_reg) ? S_DONE : S_ERR;
         end
         S_DONE:  state_next = S_DONE;
         S_ERR:   state_next = S_ERR;
         default: state_next = S_IDLE;
      endcase
   end

   assign imem_we    = (state_reg == S_WRITE);
   assign imem_addr  = ADDR_W'(BASE_ADDR) + idx_reg[ADDR_W-1:0];
   assign imem_wdata = asm_word;
   assign done       = (state_reg == S_DONE);
   assign err        = (state_reg == S_ERR);
   assign cpu_rst    = (state_reg != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: replays framed byte streams and checks the written
// image, handshake and status outputs. Build with IMEM_LOADER_CSUM_EN for the checksum variant.
module tb_imem_loader;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              err;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          wr_count = 0;
   int          last_wr_cyc = 0;
   int          done_cyc = 0;
   int          first_wr_addr = -1;
   logic        done_seen = 1'b0;
   logic [31:0] mem [256];
   logic [7:0]  stream [$];

   imem_loader #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (0),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Memory model and event recorder, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         wr_count      = 0;
         first_wr_addr = -1;
         done_seen     = 1'b0;
         for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      end else begin
         if (imem_we) begin
            mem[imem_addr] = imem_wdata;
            if (wr_count == 0) first_wr_addr = int'(imem_addr);
            wr_count++;
            last_wr_cyc = cyc;
            $display("write addr %0d data %08h", imem_addr, imem_wdata);
         end
         if (done && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic send_stream();
      foreach (stream[i]) send_byte(stream[i]);
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic load_test1(input logic [7:0] csum);
      stream = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
      stream.push_back(csum);
`else
      if (csum != 8'h90) $display("note: checksum %02h unused in this build", csum);
`endif
   endtask

   task automatic check_test1_image(input string tag);
      check({tag, "_wr_count"}, 32'(wr_count), 32'd2);
      check({tag, "_mem0"}, mem[0], 32'h0000_0013);
      check({tag, "_mem1"}, mem[1], 32'h0010_0093);
      check({tag, "_first_addr"}, 32'(first_wr_addr), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_imem_we", 32'(imem_we), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // Two-word image
      load_test1(8'h90);
      send_stream();
      settle();
      check_test1_image("t1");
      check("t1_in_ready", 32'(in_ready), 32'd0);
`ifndef IMEM_LOADER_CSUM_EN
      check("t1_done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
`endif

      // Garbage ahead of the sync byte is discarded
      do_reset();
      load_test1(8'h90);
      stream.push_front(8'h5A);
      stream.push_front(8'hFF);
      stream.push_front(8'h00);
      send_stream();
      settle();
      check_test1_image("t2");

      // Empty image
      do_reset();
      stream = '{8'hA5, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CSUM_EN
      stream.push_back(8'h00);
`endif
      send_stream();
      settle();
      check("t3_done", 32'(done), 32'd1);
      check("t3_cpu_rst", 32'(cpu_rst), 32'd0);
      check("t3_wr_count", 32'(wr_count), 32'd0);
      check("t3_err", 32'(err), 32'd0);

      // Length one past the end of memory
      do_reset();
      stream = '{8'hA5, 8'h01, 8'h01};
      send_stream();
      settle();
      check("t4_err", 32'(err), 32'd1);
      check("t4_cpu_rst", 32'(cpu_rst), 32'd1);
      check("t4_in_ready", 32'(in_ready), 32'd0);
      check("t4_done", 32'(done), 32'd0);
      check("t4_wr_count", 32'(wr_count), 32'd0);
      settle();
      check("t4_err_held", 32'(err), 32'd1);
      check("t4_in_ready_held", 32'(in_ready), 32'd0);

      // Reset in the middle of a frame
      do_reset();
      stream = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
      send_stream();
      check("t5_partial_wdata", imem_wdata, 32'h0000_0013);
      rst = 1'b1;
      @(negedge clk);
      check("t5_in_ready", 32'(in_ready), 32'd1);
      check("t5_cpu_rst", 32'(cpu_rst), 32'd1);
      check("t5_imem_addr", 32'(imem_addr), 32'd0);
      check("t5_imem_wdata", imem_wdata, 32'd0);
      check("t5_imem_we", 32'(imem_we), 32'd0);
      check("t5_done", 32'(done), 32'd0);
      rst = 1'b0;
      load_test1(8'h90);
      send_stream();
      settle();
      check_test1_image("t5");

      // Full-depth image: word i = i, XOR of all bytes is 00
      do_reset();
      stream = '{8'hA5, 8'h00, 8'h01};
      for (int i = 0; i < 256; i++) begin
         stream.push_back(8'(i));
         stream.push_back(8'h00);
         stream.push_back(8'h00);
         stream.push_back(8'h00);
      end
`ifdef IMEM_LOADER_CSUM_EN
      stream.push_back(8'h00);
`endif
      send_stream();
      settle();
      check("full_wr_count", 32'(wr_count), 32'd256);
      check("full_mem1", mem[1], 32'd1);
      check("full_mem255", mem[255], 32'd255);
      check("full_done", 32'(done), 32'd1);
      check("full_err", 32'(err), 32'd0);

`ifdef IMEM_LOADER_CSUM_EN
      // Checksum mismatch
      do_reset();
      load_test1(8'h91);
      send_stream();
      settle();
      check("t6_err", 32'(err), 32'd1);
      check("t6_done", 32'(done), 32'd0);
      check("t6_cpu_rst", 32'(cpu_rst), 32'd1);
      check("t6_wr_count", 32'(wr_count), 32'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
